nock_mem_ctrl: RTL

Request/response controller that sits directly upstream of the 69-bit single-port cell RAM and is its only driver. It serialises read, write and allocate requests from the Nock traversal engine into RAM cycles and absorbs the RAM's registered-address read timing. It also owns the bump-allocator free pointer for new cells.

---
 rtl/nock_mem_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/nock_mem_ctrl.sv
// nock_mem_ctrl: request/response front end for the single-port cell RAM.
// Serialises read / write / alloc requests into RAM cycles, absorbs the
// RAM's registered-address read latency, and owns the bump-allocator
// free pointer.
//
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   req_*            : request handshake (op 00 rd, 01 wr, 10 alloc, 11 rd)
//   resp_*           : one-cycle response pulse with data/addr/err
//   free_ptr         : next allocation address (saturates at MEM_DEPTH)
//   mem_full         : free_ptr == MEM_DEPTH
//   ram_*            : registered RAM drive, ram_q read data back
//
// Optional feature: define MEM_CTRL_BOUNDS_CHECK_EN to refuse read/write
// requests whose address is >= MEM_DEPTH (response carries resp_err).
module nock_mem_ctrl #(
  parameter int DATA_W    = 69,
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int HEAP_BASE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err,
  output logic [ADDR_W:0]   free_ptr,
  output logic              mem_full,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] BASE_C  = (ADDR_W+1)'(HEAP_BASE);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     free_ptr_q, free_ptr_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;     // address reported in the response
  logic                wr_q, wr_d;         // response echoes written data
  logic                err_q, err_d;       // request was refused
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
  logic                resp_err_q, resp_err_d;
  logic                full, oob;

  assign full = (free_ptr_q == DEPTH_C);

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  assign oob = ({1'b0, req_addr} >= DEPTH_C);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    free_ptr_d    = free_ptr_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;            // single-cycle write strobe
    addr_d        = addr_q;
    wr_d          = wr_q;
    err_d         = err_q;
    resp_valid_d  = 1'b0;            // single-cycle response pulse
    resp_data_d   = resp_data_q;
    resp_addr_d   = resp_addr_q;
    resp_err_d    = resp_err_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        state_d = ISSUE;
        wr_d    = (req_op == 2'b01) || (req_op == 2'b10);
        if (req_op == 2'b10) begin
          addr_d = free_ptr_q[ADDR_W-1:0];
          err_d  = full;
          // A refused alloc leaves the RAM and free pointer untouched.
          if (!full) begin
            ram_address_d = free_ptr_q[ADDR_W-1:0];
            ram_data_d    = req_data;
            ram_wren_d    = 1'b1;
            free_ptr_d    = free_ptr_q + 1'b1;
          end
        end else begin
          addr_d = req_addr;
          err_d  = oob;
          if (!oob) begin
            ram_address_d = req_addr;
            ram_data_d    = req_data;
            ram_wren_d    = (req_op == 2'b01);
          end
        end
      end
      ISSUE: state_d = CAPTURE;      // RAM samples address/wren this edge
      CAPTURE: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_addr_d  = addr_q;
        resp_err_d   = err_q;
        // ram_data_q still holds the written word, so it serves as the echo.
        resp_data_d  = err_q ? '0 : (wr_q ? ram_data_q : ram_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      free_ptr_q    <= BASE_C;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_addr_q   <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      free_ptr_q    <= free_ptr_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      addr_q        <= addr_d;
      wr_q          <= wr_d;
      err_q         <= err_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_addr_q   <= resp_addr_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_addr   = resp_addr_q;
  assign resp_err    = resp_err_q;
  assign free_ptr    = free_ptr_q;
  assign mem_full    = full;
  assign ram_data    = ram_data_q;
  assign ram_address = ram_address_q;
  assign ram_wren    = ram_wren_q;

endmodule
